// File: rtl/bfp16_mult_pipe.sv
// LANES-wide BF16 multiplier with RNE/RTZ rounding, DAZ inputs, flush-to-zero outputs and sticky flags.
// Fixed 3-cycle latency; the whole pipe stalls as one unit while a result waits and out_ready is low.
module bfp16_mult_pipe #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*LANES-1:0]  in_a,
  input  logic [16*LANES-1:0]  in_b,
  input  logic                 in_rnd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*LANES-1:0]  out_o,
  output logic [4*LANES-1:0]   out_exc,
  output logic [3:0]           flags,
  input  logic                 flags_clear
);

  localparam int LATENCY = 3;

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_NAN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_ZERO = 2'd3;

  typedef struct packed {
    logic        sign;
    logic [1:0]  cls;
    logic        inv;
    logic [9:0]  esum;
    logic [15:0] prod;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic [1:0]  cls;
    logic        inv;
    logic [9:0]  expo;
    logic [7:0]  mant;
    logic        g;
    logic        r;
    logic        st;
  } s2_t;

  logic                 adv;
  logic [LATENCY-1:0]   vld_q;
  logic [1:0]           rnd_q;
  logic [16*LANES-1:0]  out_d;
  logic [16*LANES-1:0]  out_q;
  logic [4*LANES-1:0]   exc_d;
  logic [4*LANES-1:0]   exc_q;
  logic [3:0]           exc_or;
  logic [3:0]           flags_d;
  logic [3:0]           flags_q;

  assign out_valid = vld_q[LATENCY-1];
  assign in_ready  = ~out_valid | out_ready;
  assign adv       = in_ready;
  assign out_o     = out_q;
  assign out_exc   = exc_q;
  assign flags     = flags_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [15:0] a;
    logic [15:0] b;
    logic        a_nan, a_inf, a_zero;
    logic        b_nan, b_inf, b_zero;
    logic        inv;
    s1_t         s1_d, s1_q;
    s2_t         s2_d, s2_q;
    logic        up;
    logic        carry;
    logic [8:0]  m9;
    logic [6:0]  frac;
    logic [9:0]  expf;
    logic [15:0] res;
    logic [3:0]  exc;

    assign a      = in_a[16*i +: 16];
    assign b      = in_b[16*i +: 16];
    assign a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
    assign a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
    assign a_zero = (a[14:7] == 8'h00);
    assign b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
    assign b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
    assign b_zero = (b[14:7] == 8'h00);
    assign inv    = (a_inf & b_zero) | (b_inf & a_zero);

    // Subnormal inputs share the zero class (exp == 0), so inf x subnormal is invalid too.
    always_comb begin
      s1_d.sign = a[15] ^ b[15];
      s1_d.inv  = inv;
      if (a_nan | b_nan | inv)  s1_d.cls = CLS_NAN;
      else if (a_inf | b_inf)   s1_d.cls = CLS_INF;
      else if (a_zero | b_zero) s1_d.cls = CLS_ZERO;
      else                      s1_d.cls = CLS_NORM;
      s1_d.esum = {2'b00, a[14:7]} + {2'b00, b[14:7]};
      s1_d.prod = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    end

    always_comb begin
      s2_d.sign = s1_q.sign;
      s2_d.cls  = s1_q.cls;
      s2_d.inv  = s1_q.inv;
      s2_d.expo = s1_q.esum - 10'd127 + {9'd0, s1_q.prod[15]};
      if (s1_q.prod[15]) begin
        s2_d.mant = s1_q.prod[15:8];
        s2_d.g    = s1_q.prod[7];
        s2_d.r    = s1_q.prod[6];
        s2_d.st   = |s1_q.prod[5:0];
      end else begin
        s2_d.mant = s1_q.prod[14:7];
        s2_d.g    = s1_q.prod[6];
        s2_d.r    = s1_q.prod[5];
        s2_d.st   = |s1_q.prod[4:0];
      end
    end

    // Rounding carry-out leaves mantissa 1.0000000 and bumps the exponent before the range check.
    always_comb begin
      up    = ~rnd_q[1] & s2_q.g & (s2_q.r | s2_q.st | s2_q.mant[0]);
      m9    = {1'b0, s2_q.mant} + {8'd0, up};
      carry = m9[8];
      frac  = carry ? m9[7:1] : m9[6:0];
      expf  = s2_q.expo + {9'd0, carry};
      res   = {s2_q.sign, expf[7:0], frac};
      exc   = {3'b000, s2_q.g | s2_q.r | s2_q.st};
      case (s2_q.cls)
        CLS_NAN: begin
          res = 16'h7FC0;
          exc = {s2_q.inv, 3'b000};
        end
        CLS_INF: begin
          res = {s2_q.sign, 15'h7F80};
          exc = 4'b0000;
        end
        CLS_ZERO: begin
          res = {s2_q.sign, 15'h0000};
          exc = 4'b0000;
        end
        default: begin
          if ($signed(expf) >= 10'sd255) begin
            res = {s2_q.sign, rnd_q[1] ? 15'h7F7F : 15'h7F80};
            exc = 4'b0101;
          end else if ($signed(expf) <= 10'sd0) begin
            res = {s2_q.sign, 15'h0000};
            exc = 4'b0011;
          end
        end
      endcase
    end

    assign out_d[16*i +: 16] = res;
    assign exc_d[4*i +: 4]   = exc;

    always_ff @(posedge clk) begin
      if (adv) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
      end
    end
  end

  // A clear coinciding with a transfer still keeps that transfer's bits.
  always_comb begin
    exc_or = 4'b0000;
    for (int i = 0; i < LANES; i++) exc_or = exc_or | exc_q[4*i +: 4];
    flags_d = flags_clear ? 4'b0000 : flags_q;
    if (out_valid && out_ready) flags_d = flags_d | exc_or;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      rnd_q   <= '0;
      out_q   <= '0;
      exc_q   <= '0;
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
      if (adv) begin
        vld_q <= {vld_q[LATENCY-2:0], in_valid};
        rnd_q <= {rnd_q[0], in_rnd};
        if (vld_q[LATENCY-2]) begin
          out_q <= out_d;
          exc_q <= exc_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_bfp16_mult_pipe.sv
// Scoreboard bench for bfp16_mult_pipe: directed BF16 cases, random streams, backpressure and reset.
module tb_bfp16_mult_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_rnd, out_valid, out_ready, flags_clear;
  logic [63:0] in_a, in_b, out_o;
  logic [15:0] out_exc;
  logic [3:0]  flags;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed { logic [63:0] o; logic [15:0] e; } res_t;
  typedef struct packed { logic [63:0] a; logic [63:0] b; logic rnd; logic [63:0] o; logic [15:0] e; } vec_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  bfp16_mult_pipe #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o), .out_exc(out_exc),
    .flags(flags), .flags_clear(flags_clear)
  );

  // Reference: exact product in double precision, then rounded to a 7-bit fraction.
  function automatic logic [19:0] ref_lane(input logic [15:0] x, input logic [15:0] y, input logic rtz);
    logic s, xn, yn, xi, yi, xz, yz, up, inex;
    real rx, ry, p;
    logic [63:0] pb;
    logic [6:0] m;
    logic [44:0] rest;
    int e;
    s  = x[15] ^ y[15];
    xn = (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    yn = (y[14:7] == 8'hFF) && (y[6:0] != 7'd0);
    xi = (x[14:7] == 8'hFF) && (x[6:0] == 7'd0);
    yi = (y[14:7] == 8'hFF) && (y[6:0] == 7'd0);
    xz = (x[14:7] == 8'h00);
    yz = (y[14:7] == 8'h00);
    if (xn || yn) return {4'b0000, 16'h7FC0};
    if ((xi && yz) || (yi && xz)) return {4'b1000, 16'h7FC0};
    if (xi || yi) return {4'b0000, s, 15'h7F80};
    if (xz || yz) return {4'b0000, s, 15'h0000};
    rx = $bitstoreal({1'b0, 11'(int'(x[14:7]) + 896), x[6:0], 45'd0});
    ry = $bitstoreal({1'b0, 11'(int'(y[14:7]) + 896), y[6:0], 45'd0});
    p  = rx * ry;
    pb = $realtobits(p);
    e    = int'(pb[62:52]) - 1023 + 127;
    m    = pb[51:45];
    rest = pb[44:0];
    inex = |rest;
    up   = !rtz && rest[44] && ((|rest[43:0]) || m[0]);
    if (up) begin
      if (m == 7'h7F) begin m = 7'd0; e++; end
      else m = m + 7'd1;
    end
    if (e >= 255) return {4'b0101, s, rtz ? 15'h7F7F : 15'h7F80};
    if (e <= 0) return {4'b0011, s, 15'h0000};
    return {3'b000, inex, s, e[7:0], m};
  endfunction

  function automatic res_t ref_vec(input logic [63:0] a, input logic [63:0] b, input logic rtz);
    res_t r;
    logic [19:0] l;
    for (int i = 0; i < 4; i++) begin
      l = ref_lane(a[16*i +: 16], b[16*i +: 16], rtz);
      r.o[16*i +: 16] = l[15:0];
      r.e[4*i +: 4]   = l[19:16];
    end
    return r;
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 3) != 0) v[14:7] = 8'($urandom_range(40, 215));
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    res_t r;
    for (int i = 0; i < 4; i++) begin
      v.a[16*i +: 16] = rnd_op();
      v.b[16*i +: 16] = rnd_op();
    end
    v.rnd = 1'($urandom_range(0, 1));
    r = ref_vec(v.a, v.b, v.rnd);
    v.o = r.o;
    v.e = r.e;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = 1'b0;
    out_ready = 1'b1; flags_clear = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out_o !== 64'd0 || out_exc !== 16'd0 || flags !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b out=%h exc=%h flags=%b, want 0/0/0/0", out_valid, out_o, out_exc, flags);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_rnd = 1'b0;
    in_a = 64'h4040_C000_4000_3F80;
    in_b = 64'h4040_3F00_4040_3FC0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (out_valid !== 1'b1 && lat < 10);
    n_vec++;
    if (lat != 3) begin n_bad++; $display("FAIL basic_latency: got %0d cycles want 3", lat); end
    n_vec++;
    if (out_o !== 64'h4110_BF80_40C0_3FC0 || out_exc !== 16'h0000) begin
      n_bad++;
      $display("FAIL basic_result: got %h/%h want 4110bf8040c03fc0/0000", out_o, out_exc);
    end
  endtask

  task automatic test_round_range();
    vec_t v[2];
    res_t r;
    int sent = 0, got = 0, cyc = 0;
    v[0] = '{a:64'h3F80_0080_7F00_3FC0, b:64'h3F80_3F00_4000_3F81, rnd:1'b0,
             o:64'h3F80_0000_7F80_3FC2, e:16'h0351};
    v[1] = '{a:64'hFF00_0080_7F00_3FC0, b:64'h4000_3F00_4000_3F81, rnd:1'b1,
             o:64'hFF7F_0000_7F7F_3FC1, e:16'h5351};
    out_ready = 1'b1;
    while (got < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      in_valid = (sent < 2);
      if (sent < 2) begin in_a = v[sent].a; in_b = v[sent].b; in_rnd = v[sent].rnd; end
      #1;
      if (in_valid && in_ready) begin r.o = v[sent].o; r.e = v[sent].e; exp_q.push_back(r); sent++; end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL round_range_extra: got %h with nothing expected", out_o); end
        else begin
          r = exp_q.pop_front();
          if (out_o !== r.o || out_exc !== r.e) begin
            n_bad++;
            $display("FAIL round_range: got %h/%h want %h/%h", out_o, out_exc, r.o, r.e);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    if (got < 2) begin n_vec++; n_bad++; $display("FAIL round_range_timeout: got %0d results want 2", got); end
    @(negedge clk);
    n_vec++;
    if (flags !== 4'b0111) begin n_bad++; $display("FAIL flags_after_range: got %b want 0111", flags); end
    flags_clear = 1'b1;
    @(negedge clk);
    flags_clear = 1'b0;
    n_vec++;
    if (flags !== 4'b0000) begin n_bad++; $display("FAIL flags_clear: got %b want 0000", flags); end
  endtask

  task automatic test_special();
    vec_t v[2];
    res_t r;
    int sent = 0, got = 0, cyc = 0;
    v[0] = '{a:64'hFF80_7FC1_8000_0001, b:64'h4000_3F80_3F80_4000, rnd:1'b0,
             o:64'hFF80_7FC0_8000_0000, e:16'h0000};
    v[1] = '{a:64'hFFC0_C000_3F80_7F80, b:64'h7F80_0000_FF80_0000, rnd:1'b1,
             o:64'h7FC0_8000_FF80_7FC0, e:16'h0008};
    out_ready = 1'b1;
    flags_clear = 1'b1;
    while (got < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      in_valid = (sent < 2);
      if (sent < 2) begin in_a = v[sent].a; in_b = v[sent].b; in_rnd = v[sent].rnd; end
      #1;
      if (in_valid && in_ready) begin r.o = v[sent].o; r.e = v[sent].e; exp_q.push_back(r); sent++; end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL special_extra: got %h with nothing expected", out_o); end
        else begin
          r = exp_q.pop_front();
          if (out_o !== r.o || out_exc !== r.e) begin
            n_bad++;
            $display("FAIL special: got %h/%h want %h/%h", out_o, out_exc, r.o, r.e);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    if (got < 2) begin n_vec++; n_bad++; $display("FAIL special_timeout: got %0d results want 2", got); end
    @(negedge clk);
    flags_clear = 1'b0;
    #1;
    n_vec++;
    if (flags !== 4'b1000) begin n_bad++; $display("FAIL flags_set_wins: got %b want 1000", flags); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    vec_t v[N];
    res_t r;
    int sent = 0, got = 0, cyc = 0;
    for (int k = 0; k < N; k++) v[k] = rand_vec();
    out_ready = 1'b1;
    while (got < N && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid = (sent < N);
      if (sent < N) begin in_a = v[sent].a; in_b = v[sent].b; in_rnd = v[sent].rnd; end
      #1;
      if (in_valid && in_ready) begin r.o = v[sent].o; r.e = v[sent].e; exp_q.push_back(r); sent++; end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_extra: got %h with nothing expected", out_o); end
        else begin
          r = exp_q.pop_front();
          if (out_o !== r.o || out_exc !== r.e) begin
            n_bad++;
            $display("FAIL b2b: got %h/%h want %h/%h", out_o, out_exc, r.o, r.e);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (got != N || cyc != N + 3) begin
      n_bad++;
      $display("FAIL b2b_throughput: %0d results in %0d cycles, want %0d in %0d", got, cyc, N, N + 3);
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 8;
    vec_t v[N];
    res_t r;
    int sent = 0, got = 0, cyc = 0;
    logic stall_prev = 1'b0;
    logic [63:0] held_o;
    logic [15:0] held_e;
    for (int k = 0; k < N; k++) v[k] = rand_vec();
    while (got < N && cyc < 200) begin
      @(negedge clk);
      if (stall_prev) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_o !== held_o || out_exc !== held_e) begin
          n_bad++;
          $display("FAIL bp_hold: got %b/%h/%h want 1/%h/%h", out_valid, out_o, out_exc, held_o, held_e);
        end
      end
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      cyc++;
      in_valid = (sent < N);
      if (sent < N) begin in_a = v[sent].a; in_b = v[sent].b; in_rnd = v[sent].rnd; end
      #1;
      stall_prev = out_valid && !out_ready;
      if (stall_prev) begin
        held_o = out_o;
        held_e = out_exc;
        n_vec++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      end
      if (in_valid && in_ready) begin r.o = v[sent].o; r.e = v[sent].e; exp_q.push_back(r); sent++; end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra: got %h with nothing expected", out_o); end
        else begin
          r = exp_q.pop_front();
          if (out_o !== r.o || out_exc !== r.e) begin
            n_bad++;
            $display("FAIL bp_order: got %h/%h want %h/%h", out_o, out_exc, r.o, r.e);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (got != N || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_count: got %0d results, %0d left, want %0d and 0", got, exp_q.size(), N);
    end
  endtask

  task automatic test_reset_inflight();
    int lat = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = {4{rnd_op()}};
      in_b = {4{rnd_op()}};
      in_rnd = 1'b0;
      if (k == 2) rst = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || flags !== 4'b0000 || out_o !== 64'd0) begin
      n_bad++;
      $display("FAIL rst_inflight: valid=%b flags=%b out=%h want 0/0000/0", out_valid, flags, out_o);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stale: out_valid=%b want 0 at cycle %0d", out_valid, k); end
    end
    in_valid = 1'b1;
    in_a = 64'h4040_C000_4000_3F80;
    in_b = 64'h4040_3F00_4040_3FC0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (out_valid !== 1'b1 && lat < 10);
    n_vec++;
    if (lat != 3 || out_o !== 64'h4110_BF80_40C0_3FC0 || out_exc !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_fresh: latency %0d out %h/%h want 3 4110bf8040c03fc0/0000", lat, out_o, out_exc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_range();
    test_special();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
